// File: rtl/mem_types.sv
// rtl/mem_types.sv - shared arbiter state encoding and registered bus-request layout
package mem_types;

    // Struct fields are sized for the widest supported bus; instances use the low bits.
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        ME_BUSY = 2'd2
    } arbState_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [BUS_BE_W-1:0]   be;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } busReq_t;

endpackage

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - bus wait-cycle counter that flags expiry on the last allowed wait cycle
module bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iLoad,
    input  logic iCount,
    output logic oExpire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge iClk) begin
        if (iRst || iLoad) begin
            cnt <= '0;
        end else if (iCount && !oExpire) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the wait cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1.
    assign oExpire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch (IF) and load/store (ME) stages
module mem_arbiter
    import mem_types::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iIF_req,
    input  logic [ADDR_W-1:0]   iIF_addr,
    input  logic                iFlush_IF,
    input  logic                iAdv_IF,
    output logic [DATA_W-1:0]   oIF_rdata,
    output logic                oStall_IF,
    input  logic                iME_req,
    input  logic                iME_we,
    input  logic [DATA_W/8-1:0] iME_be,
    input  logic [ADDR_W-1:0]   iME_addr,
    input  logic [DATA_W-1:0]   iME_wdata,
    input  logic                iAdv_ME,
    output logic [DATA_W-1:0]   oME_rdata,
    output logic                oStall_ME,
    output logic                oBus_req,
    output logic                oBus_we,
    output logic [DATA_W/8-1:0] oBus_be,
    output logic [ADDR_W-1:0]   oBus_addr,
    output logic [DATA_W-1:0]   oBus_wdata,
    input  logic                iBus_ack,
    input  logic [DATA_W-1:0]   iBus_rdata,
    output logic                oBus_err
);

    arbState_e         state, stateNext;
    busReq_t           busQ, busD;
    logic              doneIF, doneME, discardIF, busErr;
    logic [DATA_W-1:0] ifRdata, meRdata, finData;
    logic              finish, timedOut;
    logic              timerLoad, timerCount, timerExpire;

    bus_timer #(.TIMEOUT(TIMEOUT)) uTimer (
        .iClk    (iClk),
        .iRst    (iRst),
        .iLoad   (timerLoad),
        .iCount  (timerCount),
        .oExpire (timerExpire)
    );

    always_comb begin
        stateNext  = state;
        busD       = busQ;
        timerLoad  = 1'b0;
        timerCount = 1'b0;
        finish     = 1'b0;
        timedOut   = 1'b0;
        case (state)
            IDLE: begin
                if (iME_req && !doneME) begin
                    stateNext  = ME_BUSY;
                    busD.req   = 1'b1;
                    busD.we    = iME_we;
                    busD.be    = BUS_BE_W'(iME_be);
                    busD.addr  = BUS_ADDR_W'(iME_addr);
                    busD.wdata = BUS_DATA_W'(iME_wdata);
                    timerLoad  = 1'b1;
                end else if (iIF_req && !doneIF && !iFlush_IF) begin
                    // A fetch flushed in the same cycle is wrong-path; do not issue it.
                    stateNext  = IF_BUSY;
                    busD.req   = 1'b1;
                    busD.we    = 1'b0;
                    busD.be    = '1;
                    busD.addr  = BUS_ADDR_W'(iIF_addr);
                    busD.wdata = '0;
                    timerLoad  = 1'b1;
                end
            end
            IF_BUSY, ME_BUSY: begin
                if (iBus_ack) begin
                    finish = 1'b1;
                end else if (timerExpire) begin
                    finish   = 1'b1;
                    timedOut = 1'b1;
                end else begin
                    timerCount = 1'b1;
                end
                if (finish) begin
                    stateNext = IDLE;
                    busD      = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
        finData = timedOut ? '0 : iBus_rdata;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            busQ      <= '0;
            busErr    <= 1'b0;
            doneIF    <= 1'b0;
            doneME    <= 1'b0;
            discardIF <= 1'b0;
            ifRdata   <= '0;
            meRdata   <= '0;
        end else begin
            state  <= stateNext;
            busQ   <= busD;
            busErr <= timedOut;

            if (state == IF_BUSY && iFlush_IF) begin
                discardIF <= 1'b1;
            end else if (state == IDLE) begin
                discardIF <= 1'b0;
            end

            // Completion outranks an advance in the same cycle.
            if (finish && state == IF_BUSY && !discardIF && !iFlush_IF) begin
                doneIF  <= 1'b1;
                ifRdata <= finData;
            end else if (iAdv_IF || iFlush_IF) begin
                doneIF <= 1'b0;
            end

            if (finish && state == ME_BUSY) begin
                doneME  <= 1'b1;
                meRdata <= finData;
            end else if (iAdv_ME) begin
                doneME <= 1'b0;
            end
        end
    end

    assign oIF_rdata  = ifRdata;
    assign oME_rdata  = meRdata;
    assign oStall_IF  = !iRst && iIF_req && !doneIF;
    assign oStall_ME  = !iRst && iME_req && !doneME;
    assign oBus_req   = busQ.req;
    assign oBus_we    = busQ.we;
    assign oBus_be    = busQ.be[DATA_W/8-1:0];
    assign oBus_addr  = busQ.addr[ADDR_W-1:0];
    assign oBus_wdata = busQ.wdata[DATA_W-1:0];
    assign oBus_err   = busErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iIF_req;
    logic [31:0] iIF_addr;
    logic        iFlush_IF;
    logic        iAdv_IF;
    logic [31:0] oIF_rdata;
    logic        oStall_IF;
    logic        iME_req;
    logic        iME_we;
    logic [3:0]  iME_be;
    logic [31:0] iME_addr;
    logic [31:0] iME_wdata;
    logic        iAdv_ME;
    logic [31:0] oME_rdata;
    logic        oStall_ME;
    logic        oBus_req;
    logic        oBus_we;
    logic [3:0]  oBus_be;
    logic [31:0] oBus_addr;
    logic [31:0] oBus_wdata;
    logic        iBus_ack;
    logic [31:0] iBus_rdata;
    logic        oBus_err;

    int nCmp = 0;
    int nBad = 0;
    int stallCnt, errSeen, reqLow;

    mem_arbiter dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iIF_req    (iIF_req),
        .iIF_addr   (iIF_addr),
        .iFlush_IF  (iFlush_IF),
        .iAdv_IF    (iAdv_IF),
        .oIF_rdata  (oIF_rdata),
        .oStall_IF  (oStall_IF),
        .iME_req    (iME_req),
        .iME_we     (iME_we),
        .iME_be     (iME_be),
        .iME_addr   (iME_addr),
        .iME_wdata  (iME_wdata),
        .iAdv_ME    (iAdv_ME),
        .oME_rdata  (oME_rdata),
        .oStall_ME  (oStall_ME),
        .oBus_req   (oBus_req),
        .oBus_we    (oBus_we),
        .oBus_be    (oBus_be),
        .oBus_addr  (oBus_addr),
        .oBus_wdata (oBus_wdata),
        .iBus_ack   (iBus_ack),
        .iBus_rdata (iBus_rdata),
        .oBus_err   (oBus_err)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        iRst = 1'b1; iIF_req = 1'b1; iIF_addr = '0; iFlush_IF = 1'b0; iAdv_IF = 1'b0;
        iME_req = 1'b1; iME_we = 1'b0; iME_be = 4'hF; iME_addr = '0; iME_wdata = '0;
        iAdv_ME = 1'b0; iBus_ack = 1'b0; iBus_rdata = '0;
        tick();
        tick();
        #1;
        chk("rst_stall_if", oStall_IF, 0);
        chk("rst_stall_me", oStall_ME, 0);
        chk("rst_bus_req", oBus_req, 0);
        chk("rst_bus_err", oBus_err, 0);
        chk("rst_if_rdata", oIF_rdata, 0);
        chk("rst_me_rdata", oME_rdata, 0);
        iRst = 1'b0; iIF_req = 1'b0; iME_req = 1'b0;
        tick();

        // Fetch 0x100 acked on the fourth bus cycle
        iIF_req = 1'b1; iIF_addr = 32'h100; stallCnt = 0;
        for (int c = 0; c < 5; c++) begin
            iBus_ack   = (c == 4);
            iBus_rdata = (c == 4) ? 32'h00A00093 : 32'h0;
            #1;
            if (c == 1) begin
                chk("if_bus_req", oBus_req, 1);
                chk("if_bus_addr", oBus_addr, 32'h100);
                chk("if_bus_we", oBus_we, 0);
                chk("if_bus_be", oBus_be, 4'hF);
            end
            if (oStall_IF) stallCnt++;
            tick();
        end
        iBus_ack = 1'b0;
        #1;
        chk("if_stall_cycles", stallCnt, 5);
        chk("if_stall_low", oStall_IF, 0);
        chk("if_rdata", oIF_rdata, 32'h00A00093);
        chk("if_bus_idle", oBus_req, 0);
        iAdv_IF = 1'b1;
        tick();
        iAdv_IF = 1'b0;
        #1;
        chk("if_done_cleared", oStall_IF, 1);
        iIF_req = 1'b0;
        tick();

        // Simultaneous requests: store wins, fetch follows
        iIF_req = 1'b1; iIF_addr = 32'h300;
        iME_req = 1'b1; iME_we = 1'b1; iME_be = 4'b0011; iME_addr = 32'h200; iME_wdata = 32'hDEADBEEF;
        #1;
        chk("both_stall_if", oStall_IF, 1);
        chk("both_stall_me", oStall_ME, 1);
        tick();
        chk("me_bus_req", oBus_req, 1);
        chk("me_bus_we", oBus_we, 1);
        chk("me_bus_be", oBus_be, 4'b0011);
        chk("me_bus_addr", oBus_addr, 32'h200);
        chk("me_bus_wdata", oBus_wdata, 32'hDEADBEEF);
        iBus_ack = 1'b1; iBus_rdata = 32'h0000CAFE;
        tick();
        iBus_ack = 1'b0;
        #1;
        chk("me_stall_low", oStall_ME, 0);
        chk("if_still_stall", oStall_IF, 1);
        chk("idle_gap", oBus_req, 0);
        chk("me_rdata", oME_rdata, 32'h0000CAFE);
        iME_req = 1'b0; iAdv_ME = 1'b1;
        tick();
        iAdv_ME = 1'b0;
        chk("if2_bus_req", oBus_req, 1);
        chk("if2_bus_addr", oBus_addr, 32'h300);
        chk("if2_bus_we", oBus_we, 0);
        chk("if2_bus_be", oBus_be, 4'hF);
        iBus_ack = 1'b1; iBus_rdata = 32'h11112222; iAdv_IF = 1'b1;
        tick();
        iBus_ack = 1'b0; iAdv_IF = 1'b0;
        #1;
        chk("ack_beats_adv", oStall_IF, 0);
        chk("if2_rdata", oIF_rdata, 32'h11112222);
        iAdv_IF = 1'b1; iIF_req = 1'b0;
        tick();
        iAdv_IF = 1'b0;

        // Flush mid-fetch of 0x104, then refetch 0x200
        iIF_req = 1'b1; iIF_addr = 32'h104;
        tick();
        chk("fl_bus_addr", oBus_addr, 32'h104);
        iFlush_IF = 1'b1;
        tick();
        iFlush_IF = 1'b0;
        iBus_ack = 1'b1; iBus_rdata = 32'h55;
        tick();
        iBus_ack = 1'b0;
        #1;
        chk("fl_stall_high", oStall_IF, 1);
        chk("fl_rdata_kept", oIF_rdata, 32'h11112222);
        chk("fl_bus_idle", oBus_req, 0);
        iIF_addr = 32'h200;
        tick();
        chk("fl_new_req", oBus_req, 1);
        chk("fl_new_addr", oBus_addr, 32'h200);
        iBus_ack = 1'b1; iBus_rdata = 32'h66;
        tick();
        iBus_ack = 1'b0;
        #1;
        chk("fl_new_rdata", oIF_rdata, 32'h66);
        chk("fl_new_stall", oStall_IF, 0);
        iAdv_IF = 1'b1; iIF_req = 1'b0;
        tick();
        iAdv_IF = 1'b0;

        // Completed load held for four cycles without advance
        iME_req = 1'b1; iME_we = 1'b0; iME_be = 4'hF; iME_addr = 32'h500;
        tick();
        iBus_ack = 1'b1; iBus_rdata = 32'h12345678;
        tick();
        iBus_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("hold_stall_me", oStall_ME, 0);
            chk("hold_me_rdata", oME_rdata, 32'h12345678);
            tick();
        end
        iAdv_ME = 1'b1;
        tick();
        iAdv_ME = 1'b0;
        #1;
        chk("hold_done_cleared", oStall_ME, 1);
        iME_req = 1'b0;
        tick();

        // Timeout: no ack for 255 bus cycles
        iME_req = 1'b1; iME_addr = 32'h400;
        tick();
        errSeen = 0; reqLow = 0;
        for (int c = 1; c <= 255; c++) begin
            if (oBus_err) errSeen++;
            if (!oBus_req) reqLow++;
            tick();
        end
        chk("to_no_early_err", errSeen, 0);
        chk("to_req_held", reqLow, 0);
        chk("to_err_pulse", oBus_err, 1);
        chk("to_stall_low", oStall_ME, 0);
        chk("to_rdata_zero", oME_rdata, 0);
        chk("to_bus_released", oBus_req, 0);
        iAdv_ME = 1'b1; iME_req = 1'b0;
        tick();
        iAdv_ME = 1'b0;
        chk("to_err_single", oBus_err, 0);

        // Reset during ME_BUSY, late ack ignored
        iME_req = 1'b1; iME_addr = 32'h600;
        tick();
        tick();
        chk("rb_busy", oBus_req, 1);
        iRst = 1'b1; iIF_req = 1'b1;
        #1;
        chk("rb_stall_me", oStall_ME, 0);
        chk("rb_stall_if", oStall_IF, 0);
        tick();
        iRst = 1'b0; iIF_req = 1'b0; iME_req = 1'b0;
        iBus_ack = 1'b1; iBus_rdata = 32'h77;
        #1;
        chk("rb_req_dropped", oBus_req, 0);
        chk("rb_no_err", oBus_err, 0);
        tick();
        iBus_ack = 1'b0; iME_req = 1'b1;
        #1;
        chk("rb_not_done", oStall_ME, 1);
        chk("rb_rdata_zero", oME_rdata, 0);
        iME_req = 1'b0; iRst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus/request address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; byte enables are DATA_W/8 bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum bus wait cycles before error completion.
REQ-004 SHALL have ports, one per line:
  iClk  input  1  sole clock, rising edge
  iRst  input  1  synchronous reset, active-high
  iIF_req  input  1  fetch request pending
  iIF_addr  input  ADDR_W  fetch address
  iFlush_IF  input  1  discard current fetch (branch taken)
  iAdv_IF  input  1  IF stage registers capture this cycle
  oIF_rdata  output  DATA_W  fetched word
  oStall_IF  output  1  fetch not yet satisfied
  iME_req  input  1  load/store request pending
  iME_we  input  1  1 = store
  iME_be  input  DATA_W/8  byte enables
  iME_addr  input  ADDR_W  data address
  iME_wdata  input  DATA_W  store data
  iAdv_ME  input  1  ME stage registers capture this cycle
  oME_rdata  output  DATA_W  load data
  oStall_ME  output  1  access not yet satisfied
  oBus_req, oBus_we, oBus_be, oBus_addr, oBus_wdata  output  1/1/DATA_W/8/ADDR_W/DATA_W  single memory port
  iBus_ack  input  1  memory completes transaction
  iBus_rdata  input  DATA_W  read data, valid with iBus_ack
  oBus_err  output  1  one-cycle pulse on timeout

Function
REQ-005 SHALL implement FSM states IDLE, IF_BUSY, ME_BUSY.
REQ-006 SHALL, in IDLE, grant ME over IF when both port requests are pending and not done; no grant when neither pending.
REQ-007 SHALL register the bus request: grant at edge N drives oBus_req=1 with stable addr/we/be/wdata from cycle N+1 until the iBus_ack cycle inclusive; IF grants drive oBus_we=0, oBus_be=all ones.
REQ-008 SHALL never preempt an in-flight transaction; a new request waits until return to IDLE.
REQ-009 SHALL, on iBus_ack, latch iBus_rdata into the granted port's rdata register, set that port's done flag, return to IDLE; the zero-wait path is acknowledge at first bus-request cycle.
REQ-010 SHALL drive oStall_X = iX_req & ~done_X combinationally from the registered flag only; oStall_X SHALL NOT depend on iAdv_X (no combinational loop).
REQ-011 SHALL hold done_X and oX_rdata until the edge where iAdv_X=1, then clear done_X.
REQ-012 SHALL treat iAdv_X and ack in the same cycle for the same port as ack wins (done_X set).
REQ-013 SHALL, on iFlush_IF during IF_BUSY, complete the bus transaction but discard data (done_IF stays 0); on iFlush_IF with done_IF=1, clear done_IF.
REQ-014 SHALL count bus wait cycles in *_BUSY; on reaching TIMEOUT without ack, pulse oBus_err, complete with rdata=0, set done, return to IDLE.
REQ-015 SHALL allow back-to-back: grant of the next request at the same edge the done flag of the other port is set is not required; minimum one IDLE cycle between transactions.

Reset
REQ-016 SHALL, while iRst=1, force FSM=IDLE, oBus_req=0, oBus_err=0, done flags=0, rdata registers=0, counter=0, oStall_IF=oStall_ME=0.
REQ-017 SHALL abandon an in-flight transaction on reset mid-operation; a late iBus_ack after reset SHALL be ignored in IDLE.

Structure
REQ-018 SHALL place the state enum and a bus-request struct (req, we, be, addr, wdata) in shared package mem_types.
REQ-019 SHALL instantiate one sub-module bus_timer (load/count/expire) for the timeout counter.

Verification
REQ-020 IF fetch 0x100, memory ack after 3 cycles with 0x00A00093 -> oStall_IF high 5 cycles, then oIF_rdata=0x00A00093, stall low.
REQ-021 IF and ME both request same cycle, ME store 0x200 be=4'b0011 -> ME granted first, bus shows we=1 be=0011; IF granted after.
REQ-022 iFlush_IF asserted mid-fetch of 0x104 -> done_IF stays 0, oStall_IF stays high; new fetch 0x200 issued next IDLE.
REQ-023 No ack for 255 cycles -> oBus_err single pulse, rdata=0, stall drops next cycle.
REQ-024 iRst asserted during ME_BUSY, then ack -> oBus_req=0 next cycle, no done set, stalls 0.
REQ-025 iAdv_ME held 0 for 4 cycles after completion -> oME_rdata stable, oStall_ME low throughout, done clears on iAdv_ME edge.
